// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-ported memory.
// Each access takes three cycles: arbitrate/latch (IDLE), drive memory
// (ACCESS), return data and ready to the winner (RESP).
// Define MEM_ARB_RR_EN for round-robin arbitration. Without it, m0 has fixed
// priority and m1 is guaranteed a grant after MAX_BURST consecutive m0
// grants taken while m1 was waiting.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | memory port quiet; pick a winner and latch its request
// ST_ACCESS | latched request driven onto the memory port
// ST_RESP   | memory data returned, winner's ready pulsed
module mem_arbiter #(
   parameter int MAX_BURST = 4
) (
   input  logic        CLK,
   input  logic        SW1,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wmask,
   input  logic        m0_rstrb,
   output logic [31:0] m0_rdata,
   output logic        m0_ready,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wmask,
   input  logic        m1_rstrb,
   output logic [31:0] m1_rdata,
   output logic        m1_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   output logic        mem_rstrb,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   logic [1:0]  state;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [3:0]  lat_wmask;
   logic        lat_rstrb;
   logic        grant_m1;
   logic        m0_req;
   logic        m1_req;
   logic        pick_m1;
   logic        arbitrate;
   logic        in_access;
   logic        in_resp;

   assign m0_req    = m0_rstrb | (|m0_wmask);
   assign m1_req    = m1_rstrb | (|m1_wmask);
   assign arbitrate = (state == ST_IDLE) & (m0_req | m1_req);

`ifdef MEM_ARB_RR_EN
   // Round-robin: on a tie the master that did not win last time gets it.
   // grant_m1 holds the most recent grant and resets to m1, so m0 goes first.
   always_comb begin
      pick_m1 = m1_req & (~m0_req | ~grant_m1);
   end
`else
   localparam int CW = $clog2(MAX_BURST + 1);

   logic [CW-1:0] burst_cnt;

   // Fixed priority to m0 unless m1 has already waited through MAX_BURST m0 grants.
   always_comb begin
      pick_m1 = m1_req & (~m0_req | (burst_cnt == CW'(MAX_BURST)));
   end

   // Count m0 grants taken while m1 waits; any m1 grant or m1 idle restarts the count.
   always_ff @(posedge CLK) begin
      if (SW1) begin
         burst_cnt <= '0;
      end else if (arbitrate) begin
         if (pick_m1 || !m1_req) begin
            burst_cnt <= '0;
         end else begin
            burst_cnt <= burst_cnt + 1'b1;
         end
      end
   end
`endif

   // Access sequencer; the winner's request is captured so later input changes cannot disturb it.
   always_ff @(posedge CLK) begin
      if (SW1) begin
         state     <= ST_IDLE;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wmask <= '0;
         lat_rstrb <= 1'b0;
         grant_m1  <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arbitrate) begin
                  state     <= ST_ACCESS;
                  grant_m1  <= pick_m1;
                  lat_addr  <= pick_m1 ? m1_addr  : m0_addr;
                  lat_wdata <= pick_m1 ? m1_wdata : m0_wdata;
                  lat_wmask <= pick_m1 ? m1_wmask : m0_wmask;
                  lat_rstrb <= pick_m1 ? m1_rstrb : m0_rstrb;
               end
            end
            ST_ACCESS: state <= ST_RESP;
            ST_RESP:   state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   assign in_access = (state == ST_ACCESS);
   assign in_resp   = (state == ST_RESP);

   // Memory port is only active during ACCESS; it is held at zero otherwise.
   always_comb begin
      mem_addr  = in_access ? lat_addr  : '0;
      mem_wdata = in_access ? lat_wdata : '0;
      mem_wmask = in_access ? lat_wmask : '0;
      mem_rstrb = in_access & lat_rstrb;
   end

   // Only the recorded winner sees ready and data, and only during RESP.
   always_comb begin
      m0_ready = in_resp & ~grant_m1;
      m1_ready = in_resp & grant_m1;
      m0_rdata = m0_ready ? mem_rdata : '0;
      m1_rdata = m1_ready ? mem_rdata : '0;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, max consecutive m0 grants while m1 is pending (fixed-priority mode only).
REQ-002 CLK  input  1  system clock, all state updates on rising edge.
REQ-003 SW1  input  1  reset, synchronous, active-high.
REQ-004 m0_addr  input  32  CPU byte address.
REQ-005 m0_wdata  input  32  CPU write data, lane-aligned.
REQ-006 m0_wmask  input  4  CPU byte write enables.
REQ-007 m0_rstrb  input  1  CPU read strobe.
REQ-008 m0_rdata  output  32  CPU read data.
REQ-009 m0_ready  output  1  CPU access complete, one-cycle pulse.
REQ-010 m1_addr, m1_wdata, m1_wmask, m1_rstrb, m1_rdata, m1_ready  same widths and directions as m0_*, loader/debug port.
REQ-011 mem_addr  output  32, mem_wdata  output  32, mem_wmask  output  4, mem_rstrb  output  1  shared memory port.
REQ-012 mem_rdata  input  32  memory read data, valid the cycle after mem_rstrb.

Function
REQ-013 Request for master X SHALL be mX_req = mX_rstrb | (|mX_wmask); master holds request until mX_ready.
REQ-014 States SHALL be IDLE, ACCESS, RESP; IDLE->ACCESS on any request, ACCESS->RESP always, RESP->IDLE always.
REQ-015 In IDLE with a request, arbiter SHALL pick winner, latch winner's addr/wdata/wmask/rstrb into internal registers, record grant.
REQ-016 In ACCESS, mem_* SHALL be driven from latched values; in IDLE and RESP, mem_addr, mem_wdata, mem_wmask, mem_rstrb SHALL be 0.
REQ-017 In RESP, winner's mX_ready SHALL be 1 and mX_rdata SHALL equal mem_rdata; all other cycles mX_ready=0 and mX_rdata=0.
REQ-018 Latency request-sampled-in-IDLE to ready SHALL be exactly 2 cycles; max throughput one access per 3 cycles.
REQ-019 Writes SHALL also pulse ready in RESP; rdata content for pure writes is don't-care but SHALL follow REQ-017.
REQ-020 Request with both rstrb and wmask SHALL forward both; returned data is whatever memory returns (old word).
REQ-021 Fixed-priority: m0 wins ties; counter increments on each m0 grant while m1_req=1, clears on any m1 grant or when m1_req=0 at arbitration.
REQ-022 When counter == MAX_BURST and m1_req=1, m1 SHALL win regardless of m0_req.
REQ-023 Request changes after latch (ACCESS/RESP) SHALL not affect the in-flight access.
REQ-024 Only one master SHALL ever receive ready per access; no request is dropped or duplicated.

Reset
REQ-025 SW1=1 at a rising edge SHALL force IDLE, counter=0, last-grant=m1, latched registers 0; all outputs 0 the following cycle.
REQ-026 Reset during ACCESS or RESP SHALL abort: no ready pulse issued; aborted master re-requests after reset.

Configuration
REQ-027 Macro MEM_ARB_RR_EN defined: round-robin, winner is the master not granted last when both request; counter and MAX_BURST unused.
REQ-028 MEM_ARB_RR_EN undefined: fixed priority with starvation limit per REQ-021/022.

Verification
REQ-029 m0 read addr 0x10, mem word 0xDEADBEEF -> mem_rstrb=1/mem_addr=0x10 one cycle later, m0_ready=1 with m0_rdata=0xDEADBEEF two cycles after sampling.
REQ-030 m1 write addr 0x24 wdata 0x000000AB wmask 4'b0001 -> mem_wmask=4'b0001 for exactly one cycle, then m1_ready pulse, read-back returns 0x...AB.
REQ-031 Both request continuously, fixed-priority, MAX_BURST=4 -> grant order m0,m0,m0,m0,m1 repeating.
REQ-032 Both request continuously with MEM_ARB_RR_EN -> grants alternate m0,m1,m0,m1 starting with m0 after reset.
REQ-033 SW1 pulsed during ACCESS of m0 read -> no m0_ready, mem_* = 0 next cycle, state IDLE; subsequent m0 request completes normally.
REQ-034 m0 request deasserted and address changed during ACCESS -> mem_addr keeps latched value, m0_ready still pulses once.
